i2s_receiver: RTL and testbench
===============================

I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 SHALL provide parameter SAMPLE_BITS, default 16: bits captured per channel slot (1..31).
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 255: number of in_clk cycles without a bck rise that forces resync (1..255).
REQ-003 SHALL have port in_clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port in_rst, input, 1: synchronous reset, active-high.
REQ-005 SHALL have port enable, input, 1: receive enable; low forces HUNT.
REQ-006 SHALL have port bck, input, 1: asynchronous I2S bit clock at 64fs.
REQ-007 SHALL have port lrck, input, 1: asynchronous word select; 0 = left, 1 = right.
REQ-008 SHALL have port sin, input, 1: asynchronous I2S serial data, MSB first.
REQ-009 SHALL have port out_data, output, 2*SAMPLE_BITS: {left, right} sample pair.
REQ-010 SHALL have port out_valid, output, 1: out_data holds an unconsumed pair.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts out_data when out_valid && out_ready.
REQ-012 SHALL have port overrun_tick, output, 1: one-cycle pulse when a completed pair is dropped.
REQ-013 SHALL have port frame_err_tick, output, 1: one-cycle pulse on a short slot or timeout.
REQ-014 SHALL have port overrun_count, output, 8: saturating dropped-pair count (see Configuration).

Function
REQ-015 SHALL pass bck, lrck, and sin through two-flop synchronizers clocked by in_clk before any use.
REQ-016 SHALL detect a bck rise as synchronized bck = 1 with the previous synchronized bck = 0, and SHALL sample lrck and sin only on that cycle.
REQ-017 SHALL support in_clk at 4x bck or faster; behaviour at lower in_clk rates is undefined.
REQ-018 SHALL, on each bck rise where lrck differs from its value at the previous bck rise (a slot boundary), set the bit index to 0 and discard that bit.
REQ-019 SHALL increment the bit index on each later bck rise, saturating at 63, and SHALL shift in sin at indices 1..SAMPLE_BITS, MSB first, so the MSB is captured one bck after the lrck change.
REQ-020 SHALL implement the state machine HUNT -> LEFT -> RIGHT -> LEFT.
REQ-021 HUNT: SHALL move to LEFT on a 1->0 lrck slot boundary and SHALL ignore all other activity.
REQ-022 LEFT: SHALL move to RIGHT on a 0->1 boundary if SAMPLE_BITS bits were captured; otherwise SHALL pulse frame_err_tick and go to HUNT.
REQ-023 RIGHT: SHALL form a completed pair on the bck rise that captures right bit SAMPLE_BITS.
REQ-024 RIGHT: SHALL move to LEFT on a 1->0 boundary if the pair completed; otherwise SHALL pulse frame_err_tick and go to HUNT.
REQ-025 SHALL ignore bits beyond SAMPLE_BITS in a slot.
REQ-026 SHALL, in LEFT or RIGHT, pulse frame_err_tick and enter HUNT once TIMEOUT_CYCLES consecutive in_clk cycles pass with no bck rise.
REQ-027 SHALL, when enable = 0, enter HUNT on the next cycle, discard any partial pair, and leave the output register unchanged.
REQ-028 SHALL load a completed pair into the output register and assert out_valid on the in_clk edge after the detecting cycle.
REQ-029 SHALL thereby assert out_valid exactly 4 in_clk edges after the bck pin rise carrying the final right bit.
REQ-030 SHALL clear out_valid on a cycle with out_valid && out_ready unless a new pair loads in the same cycle.
REQ-031 SHALL, when a pair completes while out_valid = 1 and out_ready = 0, keep the held pair, drop the new pair, and pulse overrun_tick.
REQ-032 SHALL, when a pair completes in the same cycle as an accept, load the new pair, keep out_valid = 1, and not pulse overrun_tick.
REQ-033 SHALL keep out_data stable while out_valid = 1 and not accepted.

Reset
REQ-034 SHALL, while in_rst = 1, set state HUNT, bit index 0, shift registers 0, synchronizers 0, and timeout counter 0.
REQ-035 SHALL, while in_rst = 1, set out_data = 0, out_valid = 0, overrun_tick = 0, frame_err_tick = 0, and overrun_count = 0.
REQ-036 SHALL, after in_rst falls mid-frame, produce no pair until a full left slot following a 1->0 boundary has been received.

Configuration
REQ-037 SHALL, with macro I2S_RX_OVERRUN_COUNT_EN defined, increment overrun_count on each overrun_tick, saturating at 255, cleared only by in_rst.
REQ-038 SHALL, with I2S_RX_OVERRUN_COUNT_EN undefined, tie overrun_count to 0 and compile no counter logic; overrun_tick is unaffected.

Verification
REQ-039 Bench SHALL cover: in_clk = 8x bck, frames of L = 16'hA5C3 and R = 16'h0F81, out_ready = 1 -> out_data = 32'hA5C30F81 with one out_valid pulse per frame, 4 in_clk after the final R bit.
REQ-040 Bench SHALL cover: reset released while lrck = 1 mid right slot -> no output for that frame; first pair after the next 1->0 lrck boundary.
REQ-041 Bench SHALL cover: out_ready = 0 for 3 frames -> first pair held, overrun_tick pulses twice, overrun_count = 2 (macro defined) or 0 (undefined).
REQ-042 Bench SHALL cover: left slot truncated to 10 bck -> frame_err_tick pulse, no out_valid, recovery on the next valid frame.
REQ-043 Bench SHALL cover: bck stopped for 300 in_clk mid-slot -> frame_err_tick at cycle 255, state HUNT; clean frames afterward decode correctly.
REQ-044 Bench SHALL cover: out_ready asserted on the exact cycle a new pair completes -> old pair accepted, new pair loaded, no overrun_tick.

Source files
------------

// File: rtl/i2s_receiver.sv
// i2s_receiver: oversampling I2S slave receiver.
// bck, lrck and sin are synchronised into in_clk, bck rises are detected,
// and left/right slots are framed by an HUNT/LEFT/RIGHT state machine.
// Each completed {left, right} pair goes into a valid/ready output
// register. A pair that arrives while the register is still full is
// dropped and reported as an overrun.
// Optional feature: define I2S_RX_OVERRUN_COUNT_EN to build the saturating
// overrun counter. When it is undefined, overrun_count is tied to zero.
module i2s_receiver #(
  parameter int SAMPLE_BITS    = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     in_clk,
  input  logic                     in_rst,
  input  logic                     enable,
  input  logic                     bck,
  input  logic                     lrck,
  input  logic                     sin,
  output logic [2*SAMPLE_BITS-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overrun_tick,
  output logic                     frame_err_tick,
  output logic [7:0]               overrun_count
);

  typedef enum logic [1:0] {ST_HUNT, ST_LEFT, ST_RIGHT} state_e;

  localparam logic [5:0] SB_IDX  = 6'(SAMPLE_BITS);
  localparam logic [5:0] IDX_MAX = 6'd63;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0] bck_sync_q, lrck_sync_q, sin_sync_q;
  logic       bck_prev_q;
  logic       bck_s, lrck_s, sin_s, bck_rise;

  state_e                   state_q, state_d;
  logic [5:0]               bit_idx_q, bit_idx_d;
  logic                     lrck_last_q, lrck_last_d;
  logic [SAMPLE_BITS-1:0]   left_sr_q, left_sr_d, right_sr_q, right_sr_d;
  logic [7:0]               to_cnt_q, to_cnt_d;
  logic                     pair_done_q, pair_done_d;
  logic [2*SAMPLE_BITS-1:0] pair_q, pair_d;
  logic                     frame_err_q, frame_err_d;
  logic [2*SAMPLE_BITS-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     overrun_q, overrun_d;

  logic                     boundary, capture, timeout;
  logic [5:0]               idx_inc;
  logic [SAMPLE_BITS-1:0]   left_shift, right_shift;

  // Two-flop synchronisers, plus a delayed copy of bck for rise detection.
  // NOTE: clocked state always uses non-blocking (<=) assignments so every
  // flop samples values from before the edge, regardless of statement order.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      bck_sync_q  <= '0;
      lrck_sync_q <= '0;
      sin_sync_q  <= '0;
      bck_prev_q  <= 1'b0;
    end else begin
      bck_sync_q  <= {bck_sync_q[0], bck};
      lrck_sync_q <= {lrck_sync_q[0], lrck};
      sin_sync_q  <= {sin_sync_q[0], sin};
      bck_prev_q  <= bck_sync_q[1];
    end
  end

  assign bck_s    = bck_sync_q[1];
  assign lrck_s   = lrck_sync_q[1];
  assign sin_s    = sin_sync_q[1];
  assign bck_rise = bck_s & ~bck_prev_q;

  // Framing, shifting, timeout and output-register next state.
  // NOTE: every variable gets its default first, so no path through this
  // block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    lrck_last_d = lrck_last_q;
    left_sr_d   = left_sr_q;
    right_sr_d  = right_sr_q;
    to_cnt_d    = to_cnt_q;
    pair_done_d = 1'b0;
    pair_d      = pair_q;
    frame_err_d = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;

    boundary    = bck_rise && (lrck_s != lrck_last_q);
    idx_inc     = (bit_idx_q == IDX_MAX) ? IDX_MAX : bit_idx_q + 6'd1;
    // Index 0 is the boundary bit, so a capture is any non-boundary rise
    // whose new index lands in 1..SAMPLE_BITS.
    capture     = bck_rise && !boundary && (idx_inc <= SB_IDX);
    left_shift  = (left_sr_q << 1) | SAMPLE_BITS'(sin_s);
    right_shift = (right_sr_q << 1) | SAMPLE_BITS'(sin_s);
    timeout     = !bck_rise && (state_q != ST_HUNT) && (to_cnt_q == TO_LAST);

    if (bck_rise) begin
      lrck_last_d = lrck_s;
      bit_idx_d   = boundary ? 6'd0 : idx_inc;
      to_cnt_d    = '0;
    end else begin
      to_cnt_d    = to_cnt_q + 8'd1;
    end

    case (state_q)
      ST_HUNT: begin
        if (boundary && !lrck_s) state_d = ST_LEFT;
      end
      ST_LEFT: begin
        if (boundary) begin
          if (bit_idx_q >= SB_IDX) begin
            state_d = ST_RIGHT;
          end else begin
            state_d     = ST_HUNT;
            frame_err_d = 1'b1;
          end
        end else if (capture) begin
          left_sr_d = left_shift;
        end
      end
      ST_RIGHT: begin
        if (boundary) begin
          if (bit_idx_q >= SB_IDX) begin
            state_d = ST_LEFT;
          end else begin
            state_d     = ST_HUNT;
            frame_err_d = 1'b1;
          end
        end else if (capture) begin
          right_sr_d = right_shift;
          if (idx_inc == SB_IDX) begin
            pair_done_d = 1'b1;
            pair_d      = {left_sr_q, right_shift};
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase

    if (timeout) begin
      state_d     = ST_HUNT;
      frame_err_d = 1'b1;
    end

    if (!enable) begin
      state_d     = ST_HUNT;
      pair_done_d = 1'b0;
      frame_err_d = 1'b0;
    end

    // The timeout counter only runs while a frame is being tracked.
    if (state_d == ST_HUNT) to_cnt_d = '0;

    // Output register: a new pair wins over an accept; if the held pair is
    // not being taken, the new pair is dropped instead.
    if (pair_done_q) begin
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end else begin
        out_data_d  = pair_q;
        out_valid_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State register for framing, shifting and the output stage.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q     <= ST_HUNT;
      bit_idx_q   <= '0;
      lrck_last_q <= 1'b0;
      left_sr_q   <= '0;
      right_sr_q  <= '0;
      to_cnt_q    <= '0;
      pair_done_q <= 1'b0;
      pair_q      <= '0;
      frame_err_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      lrck_last_q <= lrck_last_d;
      left_sr_q   <= left_sr_d;
      right_sr_q  <= right_sr_d;
      to_cnt_q    <= to_cnt_d;
      pair_done_q <= pair_done_d;
      pair_q      <= pair_d;
      frame_err_q <= frame_err_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;
  assign overrun_tick   = overrun_q;
  assign frame_err_tick = frame_err_q;

`ifdef I2S_RX_OVERRUN_COUNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (overrun_q && (ovr_cnt_q != 8'hFF)) ovr_cnt_d = ovr_cnt_q + 8'd1;
  end

  // Saturating count of dropped pairs; only in_rst clears it.
  always_ff @(posedge in_clk) begin
    if (in_rst) ovr_cnt_q <= '0;
    else        ovr_cnt_q <= ovr_cnt_d;
  end

  assign overrun_count = ovr_cnt_q;
`else
  assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: directed bench for i2s_receiver.
// in_clk runs at 8x bck. Inputs change 1 time unit after an in_clk rise,
// and DUT outputs are observed on in_clk falling edges.
module tb_i2s_receiver;

  logic        in_clk = 1'b0;
  logic        in_rst, enable, bck, lrck, sin, out_ready;
  logic [31:0] out_data;
  logic        out_valid, overrun_tick, frame_err_tick;
  logic [7:0]  overrun_count;

  int errors = 0;
  int checks = 0;

  // Monitor bookkeeping (cumulative; scenarios compare deltas).
  int          cyc         = 0;
  int          rise_cyc    = 0;
  int          valid_rises = 0;
  int          acc_count   = 0;
  int          ovr_ticks   = 0;
  int          ferr_ticks  = 0;
  int          lat_bad     = 0;
  int          ferr_lat    = 0;
  logic [31:0] acc_data    = '0;
  logic        ov_prev     = 1'b0;

  int v0, a0, o0, f0;

  i2s_receiver #(.SAMPLE_BITS(16), .TIMEOUT_CYCLES(255)) dut (
    .in_clk         (in_clk),
    .in_rst         (in_rst),
    .enable         (enable),
    .bck            (bck),
    .lrck           (lrck),
    .sin            (sin),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .overrun_tick   (overrun_tick),
    .frame_err_tick (frame_err_tick),
    .overrun_count  (overrun_count)
  );

  always #5 in_clk = ~in_clk;

  always @(posedge in_clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle; inputs seen here hold through the next rise.
  always @(negedge in_clk) begin
    ov_prev <= out_valid;
    if (out_valid && !ov_prev) begin
      valid_rises <= valid_rises + 1;
      if (cyc - rise_cyc != 4) lat_bad <= lat_bad + 1;
    end
    if (out_valid && out_ready) begin
      acc_count <= acc_count + 1;
      acc_data  <= out_data;
    end
    if (overrun_tick) ovr_ticks <= ovr_ticks + 1;
    if (frame_err_tick) begin
      ferr_ticks <= ferr_ticks + 1;
      ferr_lat   <= cyc - rise_cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  // One bck period: low half (data/lrck change), then high half. With pulse
  // set, out_ready is high only for the 4th in_clk rise after the bck rise,
  // which is the rise that loads the pair completed by this bit.
  task automatic send_bit(input logic lr, input logic d, input logic pulse);
    bck  = 1'b0;
    lrck = lr;
    sin  = d;
    repeat (4) step();
    bck      = 1'b1;
    rise_cyc = cyc;
    for (int k = 0; k < 4; k++) begin
      step();
      if (pulse && k == 2) out_ready = 1'b1;
      if (pulse && k == 3) out_ready = 1'b0;
    end
  endtask

  // Slot bit i carries v[16-i] for i in 1..16; bit 0 and 17..31 carry zero.
  task automatic send_slot(input logic lr, input logic [15:0] v, input int first,
                           input int last, input logic pulse16);
    for (int i = first; i <= last; i++)
      send_bit(lr, (i >= 1 && i <= 16) ? v[16-i] : 1'b0, pulse16 && (i == 16));
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input logic pulse);
    send_slot(1'b0, l, 0, 31, 1'b0);
    send_slot(1'b1, r, 0, 31, pulse);
  endtask

  // Tail of a right slot, so the next frame starts with a 1->0 boundary.
  task automatic preamble();
    send_slot(1'b1, 16'h0000, 28, 31, 1'b0);
  endtask

  task automatic do_reset();
    in_rst = 1'b1;
    repeat (3) step();
    in_rst = 1'b0;
    step();
  endtask

  task automatic snap();
    v0 = valid_rises;
    a0 = acc_count;
    o0 = ovr_ticks;
    f0 = ferr_ticks;
  endtask

  initial begin
    in_rst    = 1'b1;
    enable    = 1'b1;
    bck       = 1'b0;
    lrck      = 1'b0;
    sin       = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_overrun_tick", 32'(overrun_tick), 32'd0);
    check("rst_frame_err_tick", 32'(frame_err_tick), 32'd0);
    check("rst_overrun_count", 32'(overrun_count), 32'd0);
    in_rst = 1'b0;
    step();

    // Two clean frames, consumer always ready
    snap();
    preamble();
    send_frame(16'hA5C3, 16'h0F81, 1'b0);
    send_frame(16'hA5C3, 16'h0F81, 1'b0);
    check("basic_valid_pulses", 32'(valid_rises - v0), 32'd2);
    check("basic_accepts", 32'(acc_count - a0), 32'd2);
    check("basic_data", acc_data, 32'hA5C30F81);
    check("basic_latency_bad", 32'(lat_bad), 32'd0);
    check("basic_no_frame_err", 32'(ferr_ticks - f0), 32'd0);
    check("basic_valid_cleared", 32'(out_valid), 32'd0);

    // Reset released mid right slot: that frame must not be output
    snap();
    in_rst = 1'b1;
    send_slot(1'b0, 16'h1111, 0, 31, 1'b0);
    send_slot(1'b1, 16'h2222, 0, 7, 1'b0);
    in_rst = 1'b0;
    send_slot(1'b1, 16'h2222, 8, 31, 1'b0);
    send_frame(16'h8001, 16'h7FFE, 1'b0);
    check("rstmid_valid_pulses", 32'(valid_rises - v0), 32'd1);
    check("rstmid_data", acc_data, 32'h80017FFE);
    check("rstmid_no_frame_err", 32'(ferr_ticks - f0), 32'd0);

    // Consumer stalled for three frames: first pair held, two dropped
    do_reset();
    snap();
    out_ready = 1'b0;
    preamble();
    send_frame(16'hA5C3, 16'h0F81, 1'b0);
    send_frame(16'h1234, 16'h5678, 1'b0);
    send_frame(16'hFFFF, 16'h0000, 1'b0);
    check("ovr_ticks", 32'(ovr_ticks - o0), 32'd2);
    check("ovr_valid_held", 32'(out_valid), 32'd1);
    check("ovr_data_held", out_data, 32'hA5C30F81);
`ifdef I2S_RX_OVERRUN_COUNT_EN
    check("ovr_count", 32'(overrun_count), 32'd2);
`else
    check("ovr_count", 32'(overrun_count), 32'd0);
`endif
    out_ready = 1'b1;
    step();
    step();
    check("ovr_accepted_data", acc_data, 32'hA5C30F81);
    check("ovr_valid_cleared", 32'(out_valid), 32'd0);

    // Accept on the exact cycle a new pair loads: no overrun
    snap();
    out_ready = 1'b0;
    send_frame(16'hA5C3, 16'h0F81, 1'b0);
    send_frame(16'h1234, 16'h5678, 1'b1);
    check("same_cycle_no_overrun", 32'(ovr_ticks - o0), 32'd0);
    check("same_cycle_old_accepted", acc_data, 32'hA5C30F81);
    check("same_cycle_valid", 32'(out_valid), 32'd1);
    check("same_cycle_new_data", out_data, 32'h12345678);
    out_ready = 1'b1;
    step();
    step();
    check("same_cycle_new_accepted", acc_data, 32'h12345678);

    // Left slot truncated to 10 bck
    snap();
    send_slot(1'b0, 16'hA5C3, 0, 9, 1'b0);
    send_slot(1'b1, 16'h0F81, 0, 31, 1'b0);
    send_frame(16'h8001, 16'h7FFE, 1'b0);
    check("short_frame_err", 32'(ferr_ticks - f0), 32'd1);
    check("short_valid_pulses", 32'(valid_rises - v0), 32'd1);
    check("short_recovery_data", acc_data, 32'h80017FFE);

    // bck stopped for 300 in_clk mid left slot. The last rise reaches the
    // detector 2 cycles after the pin, the counter starts 1 cycle later, and
    // frame_err_tick appears after 255 further cycles: 258 from the pin.
    snap();
    send_slot(1'b0, 16'h1111, 0, 8, 1'b0);
    repeat (300) step();
    check("timeout_frame_err", 32'(ferr_ticks - f0), 32'd1);
    check("timeout_latency", 32'(ferr_lat), 32'd258);
    send_slot(1'b0, 16'h1111, 9, 31, 1'b0);
    send_slot(1'b1, 16'h2222, 0, 31, 1'b0);
    send_frame(16'hA5C3, 16'h0F81, 1'b0);
    check("timeout_valid_pulses", 32'(valid_rises - v0), 32'd1);
    check("timeout_recovery_data", acc_data, 32'hA5C30F81);
    check("timeout_single_err", 32'(ferr_ticks - f0), 32'd1);

    // Receive disabled: nothing decoded; re-enabled: decodes again
    snap();
    enable = 1'b0;
    send_frame(16'hFFFF, 16'h0000, 1'b0);
    check("disabled_no_valid", 32'(valid_rises - v0), 32'd0);
    enable = 1'b1;
    send_frame(16'h1234, 16'h5678, 1'b0);
    check("reenabled_valid_pulses", 32'(valid_rises - v0), 32'd1);
    check("reenabled_data", acc_data, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
